add_sub_serial: RTL and testbench
=================================

# add_sub_serial

Parametrised, multi-cycle signed add/subtract unit that processes its operands CHUNK bits per clock with a registered inter-chunk carry. It also reports carry, signed overflow and zero flags. It replaces the flat 64-bit ripple adder/subtractor in the ALU path where area matters more than latency. Operands are accepted and results returned over valid/ready handshakes, so the unit can be stalled by the sequential core's control FSM.

## Interface
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NUM_CHUNKS = WIDTH/CHUNK (derived, not overridable).

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  unit can accept operands.
- in1  input  WIDTH  signed operand A.
- in2  input  WIDTH  signed operand B.
- sub  input  1  0: A+B, 1: A−B (two's complement: ~B + 1).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- sum_out  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH−1 (for sub, 1 means no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  sum_out == 0.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Chunk counter idx has range 0..NUM_CHUNKS−1. There are a carry register and a result register.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch A ← in1 and Bm ← in2 ^ {WIDTH{sub}};
  - set carry register ← sub and idx ← 0;
  - clear the result register;
  - go to BUSY.
- BUSY: each cycle, {c, s} = A[idx] + Bm[idx] + carry over chunk slice idx (bits idx·CHUNK +: CHUNK).
  - Write s into the same slice of the result register; carry ← c; idx ← idx+1.
  - On idx == NUM_CHUNKS−1: register the flags and go to DONE.
- Flags, registered when the last chunk completes:
  - carry_out = final c;
  - overflow = (A[W−1] == Bm[W−1]) && (sum[W−1] != A[W−1]);
  - zero = (full result == 0).
- DONE: out_valid=1. sum_out and flags hold stable until out_ready. On out_valid && out_ready, go to IDLE; out_valid falls next cycle.
- in_ready=0 in BUSY and DONE. in1/in2/sub/in_valid are ignored there; changing them has no effect on the result in flight.
- out_ready is ignored outside DONE.
- Result register and flags keep the last result after DONE→IDLE, but sum_out is only meaningful while out_valid=1.
- Arithmetic is modulo 2^WIDTH. carry_out/overflow semantics are identical to the flat adder: sub forces carry-in 1 and inverts B.

## Timing
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, idx=0, carry=0;
  - sum_out=0, carry_out=0, overflow=0, zero=0, out_valid=0;
  - in_ready=0 while rst_n is low, 1 from the first cycle after release.
- Reset mid-BUSY or in DONE aborts the operation. The result is discarded and no out_valid pulse appears.
- Latency: with operands accepted at edge T, out_valid is high after edge T+NUM_CHUNKS. For the defaults, that is 4 cycles.
- CHUNK=WIDTH gives latency 1.
- Throughput: with out_ready held high, one result per NUM_CHUNKS+2 cycles (accept, NUM_CHUNKS compute, handshake/return to IDLE).
- Carry crosses chunk boundaries only through the carry register. There is no combinational path longer than CHUNK bits plus the zero reduction.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- WIDTH=64, CHUNK=16, add 0x0000_0000_0000_FFFF + 0x1:
  - sum_out=0x0000_0000_0001_0000, carry_out=0, overflow=0, zero=0;
  - out_valid rises exactly 4 edges after the accepting edge (carry crosses the chunk 0→1 boundary).
- Sub 5 − 5 → sum 0, zero=1, carry_out=1, overflow=0. Sub 3 − 5 → 0xFFFF_FFFF_FFFF_FFFE, carry_out=0, zero=0.
- Overflow:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, overflow=1, carry_out=0;
  - sub 0x8000_0000_0000_0000 − 1 → 0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry_out=1;
  - 0xFFFF_FFFF_FFFF_FFFF + 1 → 0, carry_out=1, overflow=0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → sum_out/flags stable, in_ready=0; a new in_valid with different operands is ignored.
  - Raise out_ready → one handshake; the next op is accepted from IDLE and produces the correct result.
- Pull rst_n low during BUSY at idx=2 → out_valid stays 0, all outputs 0 immediately. After release, in_ready=1 and a fresh 7+8 returns 15 with 4-cycle latency.
- Re-parametrise:
  - WIDTH=32, CHUNK=8: 0xFFFF_FFFF + 1 → 0, carry_out=1, zero=1, latency 4;
  - WIDTH=32, CHUNK=32: same result, latency 1.

Source files
------------

// File: rtl/add_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_serial
//  Description : Multi-cycle signed adder/subtractor. Operands are consumed
//                CHUNK bits per clock with a registered inter-chunk carry;
//                carry, signed-overflow and zero flags are produced with the
//                result. Operands and results use valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_sub_serial #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // r_alive holds in_ready low until the first clock after reset release
    logic               r_alive;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_bm;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_next;

    assign in_ready  = (r_state == S_IDLE) && r_alive;
    assign out_valid = (r_state == S_DONE);
    assign sum_out   = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == c_last_idx);
    assign w_base    = 32'(r_idx) * 32'(CHUNK);

    // One chunk of the addition; the only carry path between chunks is r_carry
    always_comb begin
        w_a_chunk  = r_a[w_base +: CHUNK];
        w_b_chunk  = r_bm[w_base +: CHUNK];
        {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK + 1)'(r_carry);
        w_sum_next = r_sum;
        w_sum_next[w_base +: CHUNK] = w_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept from IDLE, walk the chunks, hold until taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Ready gate: released one clock after reset deasserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Operand latch, chunk accumulation and flag capture on the last chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_bm        <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in
            r_a     <= in1;
            r_bm    <= in2 ^ {WIDTH{sub}};
            r_carry <= sub;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_BUSY) begin
            r_sum   <= w_sum_next;
            r_carry <= w_c;
            if (w_last) begin
                r_idx       <= '0;
                r_carry_out <= w_c;
                r_overflow  <= (r_a[WIDTH-1] == r_bm[WIDTH-1]) &&
                               (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
                r_zero      <= (w_sum_next == '0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_sub_serial
//  Description : Self-checking bench for add_sub_serial. Three instances
//                (64/16, 32/8, 32/32) share operands; each has its own
//                handshake lines. Results come from an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_serial;

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [63:0] in1_r;
    logic [63:0] in2_r;
    logic        sub_r;
    wire  [2:0]  irdy;
    wire  [2:0]  ovld;
    wire  [2:0]  co;
    wire  [2:0]  ovf;
    wire  [2:0]  zr;
    wire  [63:0] s0;
    wire  [31:0] s1;
    wire  [31:0] s2;

    int nchk;
    int nfail;

    add_sub_serial #(.WIDTH(64), .CHUNK(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in1(in1_r), .in2(in2_r), .sub(sub_r), .out_valid(ovld[0]),
        .out_ready(ordy[0]), .sum_out(s0), .carry_out(co[0]),
        .overflow(ovf[0]), .zero(zr[0])
    );

    add_sub_serial #(.WIDTH(32), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in1(in1_r[31:0]), .in2(in2_r[31:0]), .sub(sub_r), .out_valid(ovld[1]),
        .out_ready(ordy[1]), .sum_out(s1), .carry_out(co[1]),
        .overflow(ovf[1]), .zero(zr[1])
    );

    add_sub_serial #(.WIDTH(32), .CHUNK(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in1(in1_r[31:0]), .in2(in2_r[31:0]), .sub(sub_r), .out_valid(ovld[2]),
        .out_ready(ordy[2]), .sum_out(s2), .carry_out(co[2]),
        .overflow(ovf[2]), .zero(zr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int k);
        return (k == 0) ? 64 : 32;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic logic [63:0] dut_sum(input int k);
        case (k)
            0:       return s0;
            1:       return {32'h0, s1};
            default: return {32'h0, s2};
        endcase
    endfunction

    // Reference: plain modular arithmetic plus signed-interpretation overflow
    task automatic model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                         input logic s, output logic [63:0] sum, output logic c,
                         output logic v, output logic z);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] a;
        logic [63:0] b;
        logic        sa, sb, ss;
        mask = (65'd1 << w) - 65'd1;
        a    = a_in & mask[63:0];
        b    = b_in & mask[63:0];
        if (!s) begin
            full = {1'b0, a} + {1'b0, b};
            sum  = full[63:0] & mask[63:0];
            c    = full[w];
        end else begin
            sum  = (a - b) & mask[63:0];
            c    = (a >= b);
        end
        sa = a[w-1];
        sb = b[w-1];
        ss = sum[w-1];
        v  = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        z  = (sum == 64'd0);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present operands from a negedge once the instance is ready; return after accept
    task automatic start_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic s);
        int n;
        n = 0;
        while (irdy[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {63'h0, irdy[k]}, 64'h1);
        in1_r = a;
        in2_r = b;
        sub_r = s;
        iv[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (ovld[k] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_seen", {63'h0, ovld[k]}, 64'h1);
    endtask

    task automatic check_result(input int k, input logic [63:0] es, input logic ec,
                                input logic ev, input logic ez);
        check("sum", dut_sum(k), es);
        check("flags_c_v_z", {61'h0, co[k], ovf[k], zr[k]}, {61'h0, ec, ev, ez});
    endtask

    task automatic handshake(input int k);
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
        check("valid_drop", {63'h0, ovld[k]}, 64'h0);
        check("ready_back", {63'h0, irdy[k]}, 64'h1);
    endtask

    task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0] es;
        logic        ec, ev, ez;
        int          lat;
        model(width_of(k), a, b, s, es, ec, ev, ez);
        start_op(k, a, b, s);
        wait_valid(k, lat);
        check("latency", 64'(lat), 64'(lat_of(k)));
        check_result(k, es, ec, ev, ez);
        handshake(k);
    endtask

    initial begin
        logic [63:0] held_sum;
        logic [2:0]  held_flags;
        logic [63:0] ra, rb;
        int          lat;
        int          sel;

        nchk  = 0;
        nfail = 0;
        rst_n = 1'b0;
        iv    = 3'b000;
        ordy  = 3'b000;
        in1_r = 64'h0;
        in2_r = 64'h0;
        sub_r = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {61'h0, irdy}, 64'h0);
        check("rst_out_valid", {61'h0, ovld}, 64'h0);
        check("rst_flags", {55'h0, co, ovf, zr}, 64'h0);
        check("rst_sum0", s0, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {61'h0, irdy}, 64'h7);

        // Directed cases on the default instance
        do_op(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        do_op(0, 64'd5, 64'd5, 1'b1);
        do_op(0, 64'd3, 64'd5, 1'b1);
        do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        do_op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b1);
        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        // Explicit expectations for the carry-crossing case as a cross-check of the model
        start_op(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_valid(0, lat);
        check("lat_carry_cross", 64'(lat), 64'd4);
        check_result(0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        handshake(0);

        // Backpressure: hold the result, try to inject new operands
        start_op(0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
        wait_valid(0, lat);
        held_sum   = s0;
        held_flags = {co[0], ovf[0], zr[0]};
        check("bp_sum", held_sum, 64'h1212_2323_3434_4545);
        in1_r = 64'hDEAD_BEEF_0000_0001;
        in2_r = 64'h0000_0000_0000_0007;
        sub_r = 1'b1;
        iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sum", s0, held_sum);
            check("bp_hold_ctl", {59'h0, co[0], ovf[0], zr[0], irdy[0], ovld[0]},
                  {59'h0, held_flags, 1'b0, 1'b1});
        end
        iv[0] = 1'b0;
        handshake(0);
        do_op(0, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0003, 1'b1);

        // Reset while BUSY at idx=2
        start_op(0, 64'h0000_0000_1234_5678, 64'h1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_partial", s0, 64'h0000_0000_1234_5679);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", s0, 64'h0);
        check("mid_rst_ctl", {59'h0, co[0], ovf[0], zr[0], irdy[0], ovld[0]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_valid_after_abort", {63'h0, ovld[0]}, 64'h0);
        end
        check("ready_after_abort", {63'h0, irdy[0]}, 64'h1);
        do_op(0, 64'd7, 64'd8, 1'b0);

        // Re-parametrised instances
        do_op(1, 64'hFFFF_FFFF, 64'h1, 1'b0);
        do_op(2, 64'hFFFF_FFFF, 64'h1, 1'b0);
        start_op(2, 64'hFFFF_FFFF, 64'h1, 1'b0);
        wait_valid(2, lat);
        check("w32c32_lat", 64'(lat), 64'd1);
        check_result(2, 64'h0, 1'b1, 1'b0, 1'b1);
        handshake(2);

        // Randomised operations on every instance
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 15; n++) begin
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                sel = $urandom_range(0, 3);
                if (sel == 1) rb = ra;
                if (sel == 2) ra = 64'hFFFF_FFFF_FFFF_FFFF;
                if (sel == 3) rb = 64'h1;
                do_op(k, ra, rb, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
